ctrl_word_exec: RTL and testbench
=================================

# ctrl_word_exec

Execution engine that sits on the far side of the control-word interface driven by our sequencers (e.g. the Fibonacci demo controller). It accepts one control word per handshake (register selects, immediate, bus-mux select, opcode, write enable), reads a 16×16 register file, drives the bus mux and ALU, optionally writes back, and returns the result and PSR flags on a valid/ready response channel. Controllers no longer own the slow-clock stepping; they issue words and wait for the response.

## Interface
- `DATA_W`, 16, datapath and register width.
- `NREGS`, 16, register count; selects are `$clog2(NREGS)` bits.
- `Clock` in 1: sole clock; all state on posedge.
- `Reset` in 1: asynchronous, active-high; clears all state.
- `CmdValid` in 1: control word present.
- `CmdReady` out 1: engine can accept; high only in IDLE.
- `SelectA` in 4: register read port A.
- `SelectB` in 4: register read port B, always ALU operand 2.
- `SelectIn` in 4: write-back destination.
- `Immediate` in 16: immediate operand.
- `MuxSelect` in 2: ALU operand 1 select: 0 Immediate, 1 RegA, 2 RegB, 3 zero.
- `OpCode` in 8: operation, see Operation.
- `WriteEnable` in 1: 1 = write result to `SelectIn`.
- `RspValid` out 1: response present.
- `RspReady` in 1: consumer takes response.
- `Result` out 16: ALU result of the completed word.
- `Flags` out 5: PSR `{C,L,F,Z,N}`.
- `OpError` out 1: completed word had an undefined opcode.

## Operation
- FSM: IDLE → READ → EXEC → RESP → IDLE.
- IDLE: `CmdReady`=1; on `CmdValid` capture whole word into command register, go READ.
- READ: latch RegA/RegB from register file (values as of this cycle).
- EXEC: compute `M` = mux output, `B` = RegB; compute result/flags; if `WriteEnable` and op writes, write `Result` to `SelectIn`; update `Flags`; go RESP.
- RESP: `RspValid`=1, `Result`/`Flags`/`OpError` held stable; on `RspReady` go IDLE.
- Opcodes (R = B op M unless noted): `0000_0101` ADD; `0000_1001` SUB (B−M); `0000_1011` CMP (no write); `0000_0001` AND; `0000_0010` OR; `0000_0011` XOR; `0000_1101` MOV (R=M); `1000_0100` LSH (R=B<<M[3:0]); `1000_0101` RSH logical.
- Flags: ADD: C=carry out, F=signed overflow. SUB: C=borrow (B<M unsigned), F=signed overflow. CMP: Z=(B==M), N=(B<M signed), L=(B<M unsigned), C/F unchanged. All other defined ops: Z=(R==0), N=R[15]; C, L, F unchanged. ADD/SUB also set Z, N from R; L unchanged.
- CMP `Result` = 0.
- Undefined opcode: `Result`=0, no write, `Flags` unchanged, `OpError`=1 for that response.
- Arithmetic modulo 2^16; shift amount ≥16 impossible (4-bit field).

## Timing
- Reset: state IDLE, all registers 0, `Flags`=0, `Result`=0, `RspValid`=0, `OpError`=0, `CmdReady`=1 after deassert.
- Accept on cycle T (CmdValid&CmdReady) → `RspValid` rises at T+3.
- Write-back visible to a word accepted at or after T+4 (its READ ≥ T+5).
- `RspReady` may be high before `RspValid`; handshake completes same cycle valid rises; next accept earliest cycle after that → throughput one word / 4 cycles with RspReady tied high.
- `CmdValid` ignored outside IDLE; inputs need only be stable on the accept edge.
- Reset mid-operation: word dropped, no write completes after Reset asserts, outputs return to reset values immediately.
- Write and read of same register in one word (`SelectIn`==`SelectA`): read sees old value.

## Structure
- Package `ctrl_word_pkg`: opcode constants, `MuxSelect` encodings, flag bit indices, FSM state enum, packed control-word struct (shared with controllers).
- Sub-module `alu16`: combinational, (M, B, OpCode, Flags_in) → (R, Flags_out, writes, err). Register file and FSM stay in top.

## Test plan
- Reset then MOV imm 0x0005 → r0, WE=1: RspValid at T+3, Result=0x0005, Z=0, N=0; r0 reads 0x0005.
- r0=5, r1=8; ADD MuxSelect=1 A=r0 B=r1 → r2: Result=0x000D, C=0, F=0; SUB same → 0x0003; CMP → Z=0, N=0, L=0.
- ADD 0x7FFF+0x0001: Result=0x8000, F=1, N=1, C=0; ADD 0xFFFF+0x0001: Result=0, C=1, Z=1.
- RspReady held low 10 cycles: Result/Flags stable, CmdReady=0, CmdValid words ignored; raise RspReady → next word accepted following cycle.
- OpCode 0xFF with WE=1 to r3: OpError=1, Result=0, r3 unchanged, Flags unchanged.
- Assert Reset during EXEC of a write to r4: r4 stays 0, RspValid=0, CmdReady=1 after release.

Source files
------------

// File: rtl/ctrl_word_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_word_pkg : shared types and encodings for the control-word interface
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ctrl_word_pkg;

  localparam int CW_DATA_W = 16;
  localparam int CW_SEL_W  = 4;
  localparam int FLAGS_W   = 5;

  localparam logic [7:0] OP_AND = 8'h01;
  localparam logic [7:0] OP_OR  = 8'h02;
  localparam logic [7:0] OP_XOR = 8'h03;
  localparam logic [7:0] OP_ADD = 8'h05;
  localparam logic [7:0] OP_SUB = 8'h09;
  localparam logic [7:0] OP_CMP = 8'h0B;
  localparam logic [7:0] OP_MOV = 8'h0D;
  localparam logic [7:0] OP_LSH = 8'h84;
  localparam logic [7:0] OP_RSH = 8'h85;

  localparam logic [1:0] MUX_IMM  = 2'd0;
  localparam logic [1:0] MUX_REGA = 2'd1;
  localparam logic [1:0] MUX_REGB = 2'd2;
  localparam logic [1:0] MUX_ZERO = 2'd3;

  // PSR layout {C,L,F,Z,N}
  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 3;
  localparam int FLAG_C = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef struct packed {
    logic [CW_SEL_W-1:0]  sel_a;
    logic [CW_SEL_W-1:0]  sel_b;
    logic [CW_SEL_W-1:0]  sel_in;
    logic [CW_DATA_W-1:0] imm;
    logic [1:0]           mux_sel;
    logic [7:0]           opcode;
    logic                 we;
  } ctrl_word_t;

endpackage

`default_nettype wire

// File: rtl/ctrl_word_exec_alu16.sv
// ---------------------------------------------------------------------------
// alu16    : combinational ALU, R = B op M, with PSR update
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu16
  import ctrl_word_pkg::*;
(
  input  logic [15:0]        m_i,
  input  logic [15:0]        b_i,
  input  logic [7:0]         op_i,
  input  logic [FLAGS_W-1:0] flags_i,
  output logic [15:0]        r_o,
  output logic [FLAGS_W-1:0] flags_o,
  output logic               wr_o,
  output logic               err_o
);

  logic [16:0] sum_w;
  logic [16:0] diff_w;
  logic        set_zn_w;

  // Bit 16 of the difference is the unsigned borrow (B < M).
  assign sum_w  = {1'b0, b_i} + {1'b0, m_i};
  assign diff_w = {1'b0, b_i} - {1'b0, m_i};

  always_comb begin
    r_o      = '0;
    flags_o  = flags_i;
    wr_o     = 1'b1;
    err_o    = 1'b0;
    set_zn_w = 1'b1;
    case (op_i)
      OP_ADD: begin
        r_o             = sum_w[15:0];
        flags_o[FLAG_C] = sum_w[16];
        flags_o[FLAG_F] = (b_i[15] == m_i[15]) && (sum_w[15] != b_i[15]);
      end
      OP_SUB: begin
        r_o             = diff_w[15:0];
        flags_o[FLAG_C] = diff_w[16];
        flags_o[FLAG_F] = (b_i[15] != m_i[15]) && (diff_w[15] != b_i[15]);
      end
      OP_CMP: begin
        wr_o            = 1'b0;
        set_zn_w        = 1'b0;
        flags_o[FLAG_Z] = (b_i == m_i);
        flags_o[FLAG_N] = ($signed(b_i) < $signed(m_i));
        flags_o[FLAG_L] = (b_i < m_i);
      end
      OP_AND:  r_o = b_i & m_i;
      OP_OR:   r_o = b_i | m_i;
      OP_XOR:  r_o = b_i ^ m_i;
      OP_MOV:  r_o = m_i;
      OP_LSH:  r_o = b_i << m_i[3:0];
      OP_RSH:  r_o = b_i >> m_i[3:0];
      default: begin
        wr_o     = 1'b0;
        err_o    = 1'b1;
        set_zn_w = 1'b0;
      end
    endcase
    if (set_zn_w) begin
      flags_o[FLAG_Z] = (r_o == '0);
      flags_o[FLAG_N] = r_o[15];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ctrl_word_exec.sv
// ---------------------------------------------------------------------------
// ctrl_word_exec : control-word execution engine (regfile + ALU + handshakes)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ctrl_word_exec
  import ctrl_word_pkg::*;
#(
  parameter int DATA_W = CW_DATA_W,
  parameter int NREGS  = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     CmdValid,
  output logic                     CmdReady,
  input  logic [$clog2(NREGS)-1:0] SelectA,
  input  logic [$clog2(NREGS)-1:0] SelectB,
  input  logic [$clog2(NREGS)-1:0] SelectIn,
  input  logic [DATA_W-1:0]        Immediate,
  input  logic [1:0]               MuxSelect,
  input  logic [7:0]               OpCode,
  input  logic                     WriteEnable,
  output logic                     RspValid,
  input  logic                     RspReady,
  output logic [DATA_W-1:0]        Result,
  output logic [FLAGS_W-1:0]       Flags,
  output logic                     OpError
);

  state_e               state_q, state_d;
  ctrl_word_t           cmd_q;
  logic [DATA_W-1:0]    rega_q, regb_q, result_q;
  logic [FLAGS_W-1:0]   flags_q;
  logic                 operr_q;
  logic [DATA_W-1:0]    regs_q [NREGS];

  logic [DATA_W-1:0]    mux_w, alu_r_w;
  logic [FLAGS_W-1:0]   alu_flags_w;
  logic                 alu_wr_w, alu_err_w;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (CmdValid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (RspReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mux_w = '0;
    case (cmd_q.mux_sel)
      MUX_IMM:  mux_w = cmd_q.imm;
      MUX_REGA: mux_w = rega_q;
      MUX_REGB: mux_w = regb_q;
      MUX_ZERO: mux_w = '0;
      default:  mux_w = '0;
    endcase
  end

  alu16 u_alu (
    .m_i     (mux_w),
    .b_i     (regb_q),
    .op_i    (cmd_q.opcode),
    .flags_i (flags_q),
    .r_o     (alu_r_w),
    .flags_o (alu_flags_w),
    .wr_o    (alu_wr_w),
    .err_o   (alu_err_w)
  );

  // Operands are latched in READ, so a word writing its own source reads the old value.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      rega_q   <= '0;
      regb_q   <= '0;
      result_q <= '0;
      flags_q  <= '0;
      operr_q  <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && CmdValid) begin
        cmd_q <= '{sel_a: SelectA, sel_b: SelectB, sel_in: SelectIn, imm: Immediate,
                   mux_sel: MuxSelect, opcode: OpCode, we: WriteEnable};
      end
      if (state_q == ST_READ) begin
        rega_q <= regs_q[cmd_q.sel_a];
        regb_q <= regs_q[cmd_q.sel_b];
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_r_w;
        flags_q  <= alu_flags_w;
        operr_q  <= alu_err_w;
        if (cmd_q.we && alu_wr_w) regs_q[cmd_q.sel_in] <= alu_r_w;
      end
    end
  end

  assign CmdReady = (state_q == ST_IDLE);
  assign RspValid = (state_q == ST_RESP);
  assign Result   = result_q;
  assign Flags    = flags_q;
  assign OpError  = operr_q;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_word_exec.sv
// Self-checking bench for ctrl_word_exec: directed scenarios plus random words
// compared against an arithmetic reference model of the register file and PSR.
`default_nettype none

module tb_ctrl_word_exec;

  logic        Clock, Reset, CmdValid, CmdReady, WriteEnable, RspValid, RspReady, OpError;
  logic [3:0]  SelectA, SelectB, SelectIn;
  logic [15:0] Immediate, Result;
  logic [1:0]  MuxSelect;
  logic [7:0]  OpCode;
  logic [4:0]  Flags;

  int errors = 0;
  int checks = 0;

  logic [15:0] mregs [16];
  logic [4:0]  mflags;

  ctrl_word_exec dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .SelectA(SelectA), .SelectB(SelectB), .SelectIn(SelectIn), .Immediate(Immediate),
    .MuxSelect(MuxSelect), .OpCode(OpCode), .WriteEnable(WriteEnable),
    .RspValid(RspValid), .RspReady(RspReady), .Result(Result), .Flags(Flags),
    .OpError(OpError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference semantics: flags index C=4 L=3 F=2 Z=1 N=0, computed with integer arithmetic.
  function automatic void model_alu(input logic [7:0] op, input logic [15:0] m, input logic [15:0] b,
                                    input logic [4:0] fin, output logic [15:0] r,
                                    output logic [4:0] fo, output logic wr, output logic err);
    int ub, um, sb, sm, t, s;
    ub = b; um = m; sb = $signed(b); sm = $signed(m);
    r = 16'h0; fo = fin; wr = 1'b1; err = 1'b0; t = 0;
    case (op)
      8'h05: begin t = ub + um; r = t[15:0]; fo[4] = (t > 65535);
                   s = sb + sm; fo[2] = (s > 32767 || s < -32768); end
      8'h09: begin t = ub - um; r = t[15:0]; fo[4] = (ub < um);
                   s = sb - sm; fo[2] = (s > 32767 || s < -32768); end
      8'h0B: begin wr = 1'b0; fo[1] = (ub == um); fo[0] = (sb < sm); fo[3] = (ub < um); end
      8'h01: r = b & m;
      8'h02: r = b | m;
      8'h03: r = b ^ m;
      8'h0D: r = m;
      8'h84: r = b << m[3:0];
      8'h85: r = b >> m[3:0];
      default: begin wr = 1'b0; err = 1'b1; end
    endcase
    if (!err && op != 8'h0B) begin
      fo[1] = (r == 16'h0);
      fo[0] = r[15];
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mregs[i] = 16'h0;
    mflags = 5'h0;
  endtask

  // Issues one word from IDLE (called #1 after a posedge), holds RspReady low for
  // 'hold' cycles of RESP while offering junk words, then completes the handshake.
  task automatic run_word(input logic [3:0] sa, input logic [3:0] sb, input logic [3:0] si,
                          input logic [15:0] imm, input logic [1:0] mux, input logic [7:0] op,
                          input logic we, input int hold,
                          output logic [15:0] res, output logic [4:0] fl, output logic oe);
    logic [15:0] m, er;
    logic [4:0]  ef;
    logic        ewr, eerr;
    int          n;
    check("cmd_ready_idle", CmdReady, 1);
    SelectA = sa; SelectB = sb; SelectIn = si; Immediate = imm;
    MuxSelect = mux; OpCode = op; WriteEnable = we; CmdValid = 1'b1;
    RspReady = (hold == 0);
    case (mux)
      2'd0: m = imm;
      2'd1: m = mregs[sa];
      2'd2: m = mregs[sb];
      default: m = 16'h0;
    endcase
    model_alu(op, m, mregs[sb], mflags, er, ef, ewr, eerr);
    @(posedge Clock); #1;
    CmdValid = 1'b0;
    SelectA = 4'($urandom); SelectB = 4'($urandom); SelectIn = 4'($urandom);
    Immediate = 16'($urandom); OpCode = 8'($urandom); WriteEnable = 1'($urandom);
    n = 0;
    while (RspValid !== 1'b1 && n < 8) begin
      @(posedge Clock); #1;
      n++;
    end
    // Accept edge plus two more edges: response valid in cycle T+3.
    check("rsp_latency", n, 2);
    res = Result; fl = Flags; oe = OpError;
    check("result", Result, er);
    check("flags", Flags, ef);
    check("op_error", OpError, eerr);
    for (int i = 0; i < hold; i++) begin
      CmdValid = 1'b1; SelectIn = 4'd9; Immediate = 16'hDEAD; MuxSelect = 2'd0;
      OpCode = 8'h0D; WriteEnable = 1'b1;
      @(posedge Clock); #1;
      check("hold_result", Result, er);
      check("hold_flags", Flags, ef);
      check("hold_cmd_ready", CmdReady, 0);
      check("hold_rsp_valid", RspValid, 1);
    end
    CmdValid = 1'b0;
    RspReady = 1'b1;
    @(posedge Clock); #1;
    check("ready_after_rsp", CmdReady, 1);
    check("valid_after_rsp", RspValid, 0);
    if (we && ewr) mregs[si] = er;
    mflags = ef;
  endtask

  logic [15:0] res;
  logic [4:0]  fl, fl_prev;
  logic        oe;
  logic [7:0]  ops [9] = '{8'h05, 8'h09, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h0D, 8'h84, 8'h85};

  initial begin
    Reset = 1'b1; CmdValid = 1'b0; RspReady = 1'b0; SelectA = '0; SelectB = '0;
    SelectIn = '0; Immediate = '0; MuxSelect = '0; OpCode = '0; WriteEnable = 1'b0;
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    check("rst_result", Result, 0);
    check("rst_flags", Flags, 0);
    check("rst_rsp_valid", RspValid, 0);
    check("rst_op_error", OpError, 0);
    check("rst_cmd_ready", CmdReady, 1);
    @(posedge Clock); #1;

    run_word(0, 0, 0, 16'h0005, 2'd0, 8'h0D, 1, 0, res, fl, oe);
    check("mov_imm_result", res, 16'h0005);
    check("mov_imm_z", fl[1], 0);
    check("mov_imm_n", fl[0], 0);
    run_word(0, 0, 0, 0, 2'd1, 8'h0D, 0, 0, res, fl, oe);
    check("r0_readback", res, 16'h0005);

    run_word(0, 0, 1, 16'h0008, 2'd0, 8'h0D, 1, 0, res, fl, oe);
    run_word(0, 1, 2, 0, 2'd1, 8'h05, 1, 0, res, fl, oe);
    check("add_result", res, 16'h000D);
    check("add_c", fl[4], 0);
    check("add_f", fl[2], 0);
    run_word(0, 1, 2, 0, 2'd1, 8'h09, 1, 0, res, fl, oe);
    check("sub_result", res, 16'h0003);
    run_word(0, 1, 2, 0, 2'd1, 8'h0B, 1, 0, res, fl, oe);
    check("cmp_result", res, 16'h0000);
    check("cmp_z", fl[1], 0);
    check("cmp_n", fl[0], 0);
    check("cmp_l", fl[3], 0);

    run_word(0, 0, 5, 16'h7FFF, 2'd0, 8'h0D, 1, 0, res, fl, oe);
    run_word(0, 5, 6, 16'h0001, 2'd0, 8'h05, 1, 0, res, fl, oe);
    check("ovf_result", res, 16'h8000);
    check("ovf_f", fl[2], 1);
    check("ovf_n", fl[0], 1);
    check("ovf_c", fl[4], 0);
    run_word(0, 0, 7, 16'hFFFF, 2'd0, 8'h0D, 1, 0, res, fl, oe);
    run_word(0, 7, 7, 16'h0001, 2'd0, 8'h05, 1, 0, res, fl, oe);
    check("carry_result", res, 16'h0000);
    check("carry_c", fl[4], 1);
    check("carry_z", fl[1], 1);

    run_word(0, 0, 8, 16'h00AA, 2'd0, 8'h0D, 1, 10, res, fl, oe);
    run_word(9, 0, 0, 0, 2'd1, 8'h0D, 0, 0, res, fl, oe);
    check("ignored_word_r9", res, 16'h0000);
    run_word(8, 0, 0, 0, 2'd1, 8'h0D, 0, 0, res, fl, oe);
    check("held_word_r8", res, 16'h00AA);

    fl_prev = fl;
    run_word(0, 0, 3, 16'h1234, 2'd0, 8'hFF, 1, 0, res, fl, oe);
    check("undef_error", oe, 1);
    check("undef_result", res, 16'h0000);
    check("undef_flags", fl, fl_prev);
    run_word(3, 0, 0, 0, 2'd1, 8'h0D, 0, 0, res, fl, oe);
    check("undef_r3", res, 16'h0000);

    // Same-register read and write: operand is the pre-write value.
    run_word(2, 2, 2, 0, 2'd1, 8'h05, 1, 0, res, fl, oe);
    check("self_add", res, 16'h0006);

    SelectIn = 4'd4; Immediate = 16'h1234; MuxSelect = 2'd0; OpCode = 8'h0D;
    WriteEnable = 1'b1; CmdValid = 1'b1;
    @(posedge Clock); #1 CmdValid = 1'b0;
    @(posedge Clock); #1 Reset = 1'b1;
    #1;
    check("midrst_rsp_valid", RspValid, 0);
    check("midrst_result", Result, 0);
    check("midrst_flags", Flags, 0);
    @(posedge Clock); #1 Reset = 1'b0;
    model_reset();
    #1 check("midrst_cmd_ready", CmdReady, 1);
    @(posedge Clock); #1;
    run_word(4, 0, 0, 0, 2'd1, 8'h0D, 0, 0, res, fl, oe);
    check("midrst_r4", res, 16'h0000);

    for (int k = 0; k < 80; k++) begin
      int sel;
      logic [7:0] op;
      logic [15:0] imm;
      sel = $urandom_range(0, 9);
      op  = (sel == 9) ? 8'($urandom) : ops[sel];
      case ($urandom_range(0, 5))
        0: imm = 16'hFFFF;
        1: imm = 16'h7FFF;
        2: imm = 16'h8000;
        default: imm = 16'($urandom);
      endcase
      run_word(4'($urandom), 4'($urandom), 4'($urandom), imm, 2'($urandom), op,
               1'($urandom_range(0, 3) != 0), $urandom_range(0, 2), res, fl, oe);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
